// File: rtl/qbuff_mem_wr.sv
// Memory-writer half of the qualifier/writer handshake: captures one sample per
// write request into the capture buffer and tracks fill level and overflow status.
module qbuff_mem_wr #(
    parameter int N = 10,
    parameter int B = 32
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         start,
    input  logic         mode,
    input  logic [B-1:0] din,
    input  logic         write,
    output logic         write_ack,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [B-1:0] mem_di,
    output logic [N:0]   count,
    output logic         full,
    output logic         wrapped,
    output logic         dropped
);

    localparam logic [2:0] IDLE_ST  = 3'd0;
    localparam logic [2:0] ARM_ST   = 3'd1;
    localparam logic [2:0] WAIT_ST  = 3'd2;
    localparam logic [2:0] WRITE_ST = 3'd3;
    localparam logic [2:0] ACK_ST   = 3'd4;

    localparam logic [N:0]   DEPTH   = {1'b1, {N{1'b0}}};
    localparam logic [N-1:0] PTR_INC = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   CNT_INC = {{N{1'b0}}, 1'b1};

    logic [2:0]   state_reg, state_next;
    logic [N-1:0] ptr_reg;
    logic [N:0]   count_reg;
    logic         mode_reg;
    logic         full_reg, wrapped_reg, dropped_reg;
    logic         ack_reg, mem_we_reg;
    logic [N-1:0] mem_addr_reg;
    logic [B-1:0] mem_di_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE_ST:  if (start) state_next = ARM_ST;
            ARM_ST:   state_next = WAIT_ST;
            WAIT_ST: begin
                // Losing start takes priority over a simultaneous request.
                if (!start)
                    state_next = IDLE_ST;
                else if (write)
                    state_next = (full_reg && !mode_reg) ? ACK_ST : WRITE_ST;
            end
            WRITE_ST: state_next = ACK_ST;
            ACK_ST:   if (!write) state_next = start ? WAIT_ST : IDLE_ST;
            default:  state_next = IDLE_ST;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= IDLE_ST;
            ptr_reg      <= '0;
            count_reg    <= '0;
            mode_reg     <= 1'b0;
            full_reg     <= 1'b0;
            wrapped_reg  <= 1'b0;
            dropped_reg  <= 1'b0;
            ack_reg      <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_di_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= (state_next == WRITE_ST);
            case (state_reg)
                ARM_ST: begin
                    ptr_reg     <= '0;
                    count_reg   <= '0;
                    full_reg    <= 1'b0;
                    wrapped_reg <= 1'b0;
                    dropped_reg <= 1'b0;
                    mode_reg    <= mode;
                end
                WAIT_ST: begin
                    if (state_next == WRITE_ST) begin
                        mem_addr_reg <= ptr_reg;
                        mem_di_reg   <= din;
                    end
                    // Full in stop mode: acknowledge straight away without writing.
                    if (state_next == ACK_ST) begin
                        dropped_reg <= 1'b1;
                        ack_reg     <= 1'b1;
                    end
                end
                WRITE_ST: begin
                    ptr_reg <= ptr_reg + PTR_INC;
                    if (count_reg != DEPTH)
                        count_reg <= count_reg + CNT_INC;
                    full_reg <= (count_reg >= DEPTH - CNT_INC);
                    if (count_reg == DEPTH && mode_reg)
                        wrapped_reg <= 1'b1;
                    ack_reg <= 1'b1;
                end
                ACK_ST: begin
                    if (!write)
                        ack_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign write_ack = ack_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_di    = mem_di_reg;
    assign count     = count_reg;
    assign full      = full_reg;
    assign wrapped   = wrapped_reg;
    assign dropped   = dropped_reg;

endmodule

// File: doc/qbuff_mem_wr.md
# qbuff_mem_wr

Memory-writer side of the qualifier/writer handshake in the axis_qbuff data path. It responds to the qualifier's `write` request by capturing one data sample into the capture buffer memory at a running address. It completes a four-phase `write`/`write_ack` handshake for every request. It also tracks fill level, and depending on `mode` either stops writing when the buffer is full or wraps around.

## Interface
Parameters:
- `N`, 10: buffer address width; depth = 2^N words.
- `B`, 32: sample/memory data width.

Ports:
- `aclk`, in, 1: clock; all logic is on the rising edge.
- `areset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: capture enable, level-sensitive. The rising edge seen in IDLE_ST arms the block and clears the pointer and status.
- `mode`, in, 1: 0 = stop when full, 1 = wrap around. Sampled on the arming edge and held until the block returns to IDLE_ST.
- `din`, in, B: sample data. Valid in the cycle `write` is first seen high.
- `write`, in, 1: write request from the qualifier.
- `write_ack`, out, 1: handshake acknowledge. Registered.
- `mem_we`, out, 1: memory write enable, one-cycle pulse.
- `mem_addr`, out, N: memory address.
- `mem_di`, out, B: memory write data.
- `count`, out, N+1: number of words written since arming, saturating at 2^N.
- `full`, out, 1: `count` == 2^N.
- `wrapped`, out, 1: at least one word was overwritten in wrap mode.
- `dropped`, out, 1: at least one request was acknowledged without writing, because the buffer was full in stop mode.

## Operation
- Reset: state = IDLE_ST. All outputs are 0: `write_ack`, `mem_we`, `mem_addr`, `mem_di`, `count`, `full`, `wrapped`, `dropped`. The internal pointer `ptr` is 0.
- States:
  - IDLE_ST: go to ARM_ST when `start` = 1.
  - ARM_ST: one cycle. Clears `ptr`, `count`, `full`, `wrapped`, `dropped`; latches `mode`. Then goes to WAIT_ST.
  - WAIT_ST:
    - `start` = 0 → IDLE_ST, even if `write` = 1 in the same cycle.
    - Else, if `write` = 1: register `din` and go to WRITE_ST. If `full` = 1 and latched mode = 0, go to ACK_ST instead and set `dropped`.
  - WRITE_ST: one cycle. `mem_we` = 1, `mem_addr` = `ptr`, `mem_di` = the registered `din`. On exit: `ptr` ← `ptr`+1 mod 2^N; `count` ← min(`count`+1, 2^N). If the write was made with `count` == 2^N in wrap mode, set `wrapped`. Go to ACK_ST.
  - ACK_ST: `write_ack` = 1. When `write` = 0, go to WAIT_ST if `start` = 1, else to IDLE_ST.
- `full`, `wrapped` and `dropped` are sticky until the next ARM_ST or reset. They are not cleared by `start` falling; their values stay readable in IDLE_ST.
- Dropping `start` mid-handshake (in WRITE_ST or ACK_ST) never aborts the handshake. The in-flight write and its ack complete first.
- `mem_we` is 0 in every state except WRITE_ST. `mem_addr` and `mem_di` hold their last values otherwise.
- Every request is acknowledged exactly once, whether or not it was written, so the qualifier can never hang.

## Timing
- Latency: `write` sampled high at edge t (in WAIT_ST) gives `mem_we` = 1 during cycle t+1, and `write_ack` = 1 from t+2.
- `write_ack` falls one cycle after `write` is sampled low in ACK_ST.
- Minimum request period is 4 cycles when the requester drops `write` in the first cycle it sees `write_ack`.
- `write` held high in WAIT_ST after the ack fell is a new request. The requester must return `write` to 0 first; a level held throughout is only acknowledged once per low phase.
- `count` and `full` update in the cycle after WRITE_ST, which is the same cycle `write_ack` rises.
- `areset` in any state forces IDLE_ST and zeroes all outputs on the next edge. A pending handshake is abandoned.
- `start` held high through reset release arms the block: IDLE_ST → ARM_ST on the first cycle after reset.

## Test plan
- Basic handshake: N=4, mode=0, `start`=1, three requests with `din`=0xA0, 0xA1, 0xA2 → `mem_we` pulses at addresses 0, 1, 2 with that data. `write_ack` rises 2 cycles after each `write` and falls 1 cycle after `write` falls. `count`=3.
- Full/stop: N=2, mode=0, six requests → four writes to addresses 0–3. `full`=1 after the fourth. Requests 5 and 6 are acked with no `mem_we`. `dropped`=1, `count`=4.
- Wrap: N=2, mode=1, six requests → writes to addresses 0, 1, 2, 3, 0, 1. `count` saturates at 4, `full`=1, `wrapped`=1, `dropped`=0.
- Stop mid-handshake: drop `start` one cycle after `write` rises → the write still occurs, `write_ack` still asserts, and the block returns to IDLE_ST after `write` falls. Re-raising `start` clears `count`, `full` and the flags, and the next write goes to address 0.
- Reset mid-handshake: assert `areset` while in ACK_ST → the next cycle has `write_ack`=0, `count`=0, all flags 0, IDLE_ST.
- Slow requester: hold `write` high 10 cycles after `write_ack` rises → exactly one `mem_we`, and `write_ack` stays high until 1 cycle after `write` falls.
